// File: rtl/axi_ic_pkg.sv
// ---------------------------------------------------------------------------
// axi_ic_pkg
// Shared definitions for the two-master AXI interconnect. The read-channel and
// write-channel arbiters both use these definitions.
//   arb_state_t : arbiter FSM states (idle / address phase / data phase)
//   GRNT_*      : grant-pair encodings, packed as {m0_grnt, m1_grnt}
// ---------------------------------------------------------------------------
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRNT_NONE = 2'b00;
    localparam logic [1:0] GRNT_M0   = 2'b10;
    localparam logic [1:0] GRNT_M1   = 2'b01;

    // A grant pair is legal when it is zero or one-hot.
    function automatic logic grnt_legal(input logic [1:0] g);
        return (g != 2'b11);
    endfunction

endpackage : axi_ic_pkg

// File: rtl/axi_rr_pick2.sv
// ---------------------------------------------------------------------------
// axi_rr_pick2
// Combinational two-input round-robin selector.
//   req0_i, req1_i : request from master 0 / master 1
//   last_grant_i   : previous winner, encoded as GRNT_M0 / GRNT_M1
//   grant_o        : winner as GRNT_M0 / GRNT_M1, or GRNT_NONE when no request
// ---------------------------------------------------------------------------
module axi_rr_pick2
    import axi_ic_pkg::*;
(
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o
);

    // Under contention, the master that did not win last time wins now.
    always_comb begin
        grant_o = GRNT_NONE;
        if (req0_i && req1_i) begin
            grant_o = (last_grant_i == GRNT_M0) ? GRNT_M1 : GRNT_M0;
        end else if (req0_i) begin
            grant_o = GRNT_M0;
        end else if (req1_i) begin
            grant_o = GRNT_M1;
        end else begin
            grant_o = GRNT_NONE;
        end
    end

endmodule : axi_rr_pick2

// File: rtl/axi_master_arbiter_r.sv
// ---------------------------------------------------------------------------
// axi_master_arbiter_r
// Read-channel arbiter for the two-master AXI interconnect. The arbiter grants
// the shared slave read path to one master per transaction, using round-robin
// order. It holds the grant from AR acceptance through the final R beat.
// Only one read is outstanding at a time.
//   ACLK, ARESETn           : clock and async active-low reset
//   m0/m1_ARVALID           : read-address requests (sampled in IDLE only)
//   m0/m1_ARLEN             : burst lengths (length check build only)
//   m_ARREADY, s_ARVALID    : AR handshake seen at the multiplexer
//   m_RVALID, s_RREADY      : R handshake seen at the multiplexer
//   m_RLAST                 : last R beat
//   m0_rgrnt, m1_rgrnt      : registered one-hot grant pair
//   len_err                 : one-cycle pulse on burst-length mismatch
// Build option: define AXI_ARB_R_LEN_CHECK_EN to enable the ARLEN beat counter.
// In that build, a beat-count/RLAST mismatch pulses len_err and releases the
// grant. Without the option, RLAST alone releases the grant and len_err is 0.
// ---------------------------------------------------------------------------
module axi_master_arbiter_r
    import axi_ic_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 m0_ARVALID,
    input  logic                 m1_ARVALID,
    input  logic [LEN_WIDTH-1:0] m0_ARLEN,
    input  logic [LEN_WIDTH-1:0] m1_ARLEN,
    input  logic                 m_ARREADY,
    input  logic                 s_ARVALID,
    input  logic                 m_RVALID,
    input  logic                 s_RREADY,
    input  logic                 m_RLAST,
    output logic                 m0_rgrnt,
    output logic                 m1_rgrnt,
    output logic                 len_err
);

    arb_state_t state_q, state_d;
    logic [1:0] grnt_q, grnt_d;
    logic [1:0] last_grant_q, last_grant_d;
    logic       len_err_q, len_err_d;
    logic [1:0] pick_s;
    logic       ar_hs_s;
    logic       r_hs_s;

    assign ar_hs_s = s_ARVALID & m_ARREADY;
    assign r_hs_s  = m_RVALID & s_RREADY;

    axi_rr_pick2 u_pick (
        .req0_i       (m0_ARVALID),
        .req1_i       (m1_ARVALID),
        .last_grant_i (last_grant_q),
        .grant_o      (pick_s)
    );

`ifdef AXI_ARB_R_LEN_CHECK_EN
    // The counter is one bit wider than ARLEN. This keeps the decrement
    // in range for every load value.
    logic [LEN_WIDTH:0] cnt_q, cnt_d;
    logic [LEN_WIDTH:0] arlen_s;
    logic               cnt_zero_s;

    assign arlen_s    = (grnt_q == GRNT_M0) ? {1'b0, m0_ARLEN} : {1'b0, m1_ARLEN};
    assign cnt_zero_s = (cnt_q == {(LEN_WIDTH+1){1'b0}});

    // Beat counter register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt_q <= {(LEN_WIDTH+1){1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_arlen_s;
    assign unused_arlen_s = ^{m0_ARLEN, m1_ARLEN};
`endif

    // State, grant, round-robin history and error-pulse registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= ARB_IDLE;
            grnt_q       <= GRNT_NONE;
            last_grant_q <= GRNT_M1;   // m0 wins the first contention
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grnt_q       <= grnt_d;
            last_grant_q <= last_grant_d;
            len_err_q    <= len_err_d;
        end
    end

    // Next-state logic. Requests are sampled only in IDLE. The grant is held
    // through ADDR and DATA, even if ARVALID is withdrawn.
    always_comb begin
        state_d      = state_q;
        grnt_d       = grnt_q;
        last_grant_d = last_grant_q;
        len_err_d    = 1'b0;
`ifdef AXI_ARB_R_LEN_CHECK_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_s != GRNT_NONE) begin
                    state_d      = ARB_ADDR;
                    grnt_d       = pick_s;
                    last_grant_d = pick_s;
                end else begin
                    grnt_d = GRNT_NONE;
                end
            end
            ARB_ADDR: begin
                if (ar_hs_s) begin
                    state_d = ARB_DATA;
`ifdef AXI_ARB_R_LEN_CHECK_EN
                    cnt_d   = arlen_s;
`endif
                end else begin
                    state_d = ARB_ADDR;
                end
            end
            ARB_DATA: begin
                if (r_hs_s && m_RLAST) begin
                    state_d = ARB_IDLE;
                    grnt_d  = GRNT_NONE;
`ifdef AXI_ARB_R_LEN_CHECK_EN
                    len_err_d = !cnt_zero_s;
                    cnt_d     = {(LEN_WIDTH+1){1'b0}};
`endif
                end else if (r_hs_s) begin
`ifdef AXI_ARB_R_LEN_CHECK_EN
                    // A beat past the announced length ends the burst. This
                    // keeps a missing RLAST from locking the grant.
                    if (cnt_zero_s) begin
                        state_d   = ARB_IDLE;
                        grnt_d    = GRNT_NONE;
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - {{LEN_WIDTH{1'b0}}, 1'b1};
                    end
`else
                    state_d = ARB_DATA;
`endif
                end else begin
                    state_d = ARB_DATA;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grnt_d  = GRNT_NONE;
            end
        endcase
    end

    assign m0_rgrnt = grnt_q[1];
    assign m1_rgrnt = grnt_q[0];
    assign len_err  = len_err_q;

endmodule : axi_master_arbiter_r

// File: tb/tb_axi_master_arbiter_r.sv
// ---------------------------------------------------------------------------
// tb_axi_master_arbiter_r
// Directed self-checking bench for axi_master_arbiter_r. Inputs change 1 time
// unit after each rising edge. Outputs are sampled at that same point, so each
// step() shows the registered result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_axi_master_arbiter_r;

    localparam int LW = 8;
`ifdef AXI_ARB_R_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          m0_ARVALID, m1_ARVALID;
    logic [LW-1:0] m0_ARLEN, m1_ARLEN;
    logic          m_ARREADY, s_ARVALID, m_RVALID, s_RREADY, m_RLAST;
    logic          m0_rgrnt, m1_rgrnt, len_err;
    logic [1:0]    g;
    logic [1:0]    exp_g;

    int checks = 0;
    int errors = 0;

    always #5 ACLK = ~ACLK;

    axi_master_arbiter_r #(.LEN_WIDTH(LW)) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .m0_ARVALID (m0_ARVALID),
        .m1_ARVALID (m1_ARVALID),
        .m0_ARLEN   (m0_ARLEN),
        .m1_ARLEN   (m1_ARLEN),
        .m_ARREADY  (m_ARREADY),
        .s_ARVALID  (s_ARVALID),
        .m_RVALID   (m_RVALID),
        .s_RREADY   (s_RREADY),
        .m_RLAST    (m_RLAST),
        .m0_rgrnt   (m0_rgrnt),
        .m1_rgrnt   (m1_rgrnt),
        .len_err    (len_err)
    );

    assign g = {m0_rgrnt, m1_rgrnt};

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic clear_inputs();
        m0_ARVALID = 1'b0; m1_ARVALID = 1'b0;
        m0_ARLEN = 8'd0;   m1_ARLEN = 8'd0;
        m_ARREADY = 1'b0;  s_ARVALID = 1'b0;
        m_RVALID = 1'b0;   s_RREADY = 1'b0; m_RLAST = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        ARESETn = 1'b0;
        step();
        step();
        ARESETn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", g); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b expected 0", len_err); end
        step();
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL idle_no_req: got %b expected 00", g); end
    endtask

    // Single master, 4 beats. The grant stays through the last beat.
    task automatic test_single_master();
        apply_reset();
        m0_ARVALID = 1'b1; s_ARVALID = 1'b1; m0_ARLEN = 8'd3;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL single_grant: got %b expected 10", g); end
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL single_addr_hold: got %b expected 10", g); end
        m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m0_ARVALID = 1'b0; s_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = (i == 3);
            step();
            exp_g = (i == 3) ? 2'b00 : 2'b10;
            checks++; if (g !== exp_g) begin errors++; $display("FAIL single_beat%0d: got %b expected %b", i, g, exp_g); end
        end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err: got %b expected 0", len_err); end
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        step();
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL single_after: got %b expected 00", g); end
    endtask

    // Both request after reset: m0 first, one-cycle bubble, then m1.
    task automatic test_contention();
        apply_reset();
        m0_ARVALID = 1'b1; m1_ARVALID = 1'b1; s_ARVALID = 1'b1;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL contend_first: got %b expected 10", g); end
        m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m0_ARVALID = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b1;
        step();
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL contend_bubble: got %b expected 00", g); end
        step();
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL contend_second: got %b expected 01", g); end
    endtask

    // Both request continuously: grants alternate and are never 11.
    task automatic test_fairness();
        apply_reset();
        m0_ARVALID = 1'b1; m1_ARVALID = 1'b1; s_ARVALID = 1'b1;
        for (int t = 0; t < 6; t++) begin
            exp_g = (t % 2 == 0) ? 2'b10 : 2'b01;
            step();
            checks++; if (g !== exp_g) begin errors++; $display("FAIL fair_txn%0d: got %b expected %b", t, g, exp_g); end
            m_ARREADY = 1'b1;
            step();
            checks++; if (g === 2'b11) begin errors++; $display("FAIL fair_onehot%0d: got %b expected not 11", t, g); end
            m_ARREADY = 1'b0;
            m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b1;
            step();
            m_RVALID = 1'b0; m_RLAST = 1'b0;
            checks++; if (g !== 2'b00) begin errors++; $display("FAIL fair_release%0d: got %b expected 00", t, g); end
        end
    endtask

    // AR handshake and a single last beat on consecutive edges.
    task automatic test_back_to_back();
        apply_reset();
        m0_ARVALID = 1'b1; s_ARVALID = 1'b1;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL b2b_grant: got %b expected 10", g); end
        m_ARREADY = 1'b1;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL b2b_data: got %b expected 10", g); end
        m_ARREADY = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b1;
        step();
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL b2b_release: got %b expected 00", g); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL b2b_len_err: got %b expected 0", len_err); end
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL b2b_regrant: got %b expected 10", g); end
    endtask

    // Async reset during beat 2 of 8. After release, a pending m1 is served first.
    task automatic test_reset_mid_burst();
        apply_reset();
        m0_ARVALID = 1'b1; s_ARVALID = 1'b1; m0_ARLEN = 8'd7;
        step();
        m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m0_ARVALID = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL rst_mid_before: got %b expected 10", g); end
        ARESETn = 1'b0;
        #1;
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL rst_mid_async: got %b expected 00", g); end
        clear_inputs();
        step();
        ARESETn = 1'b1; m1_ARVALID = 1'b1; s_ARVALID = 1'b1;
        step();
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL rst_mid_m1_first: got %b expected 01", g); end
        m0_ARVALID = 1'b1; m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m1_ARVALID = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b1;
        step();
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        step();
        checks++; if (g !== 2'b10) begin errors++; $display("FAIL rst_mid_m0_next: got %b expected 10", g); end
    endtask

    // Length mismatch handling. With the check disabled, RLAST alone releases
    // the grant and len_err stays low.
    task automatic test_len_check();
        apply_reset();
        m0_ARVALID = 1'b1; s_ARVALID = 1'b1; m0_ARLEN = 8'd3;
        step();
        m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m0_ARVALID = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b0;
        step();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_early_b1: got %b expected 0", len_err); end
        m_RLAST = 1'b1;
        step();
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        checks++; if (len_err !== LEN_CHK) begin errors++; $display("FAIL len_early_err: got %b expected %b", len_err, LEN_CHK); end
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL len_early_release: got %b expected 00", g); end
        step();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_early_pulse: got %b expected 0", len_err); end

        m1_ARVALID = 1'b1; m1_ARLEN = 8'd1;
        step();
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL len_miss_grant: got %b expected 01", g); end
        m_ARREADY = 1'b1;
        step();
        m_ARREADY = 1'b0; m1_ARVALID = 1'b0;
        m_RVALID = 1'b1; s_RREADY = 1'b1; m_RLAST = 1'b0;
        step();
        checks++; if (g !== 2'b01) begin errors++; $display("FAIL len_miss_b1: got %b expected 01", g); end
        step();
        exp_g = LEN_CHK ? 2'b00 : 2'b01;
        checks++; if (len_err !== LEN_CHK) begin errors++; $display("FAIL len_miss_err: got %b expected %b", len_err, LEN_CHK); end
        checks++; if (g !== exp_g) begin errors++; $display("FAIL len_miss_release: got %b expected %b", g, exp_g); end
        m_RLAST = 1'b1;
        step();
        m_RVALID = 1'b0; m_RLAST = 1'b0;
        checks++; if (g !== 2'b00) begin errors++; $display("FAIL len_miss_final: got %b expected 00", g); end
    endtask

    initial begin
        clear_inputs();
        ARESETn = 1'b0;
        test_reset();
        test_single_master();
        test_contention();
        test_fairness();
        test_back_to_back();
        test_reset_mid_burst();
        test_len_check();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_axi_master_arbiter_r
